// File: rtl/fetch_control.sv
// fetch_control: program counter and IF/ID pipeline register for a five-stage MIPS datapath.
// Drives the byte address into a combinational instruction memory and latches the returned word.
// Handles stall, flush and branch redirect, and detects the halt word to drain and stop.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hold PC and IF/ID
//   flush          load a bubble into IF/ID
//   branch_taken   redirect PC to branch_target
//   branch_target  redirect byte address (bits [1:0] forced to 00)
//   address        instruction-memory byte address (the PC register)
//   instruction    word returned for address, same cycle
//   if_id_instr    latched instruction (0 for a bubble)
//   if_id_pc4      latched PC+4
//   if_id_valid    latched slot holds a real instruction
//   halted         pipeline drained after halt; sticky until reset
module fetch_control #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam logic [3:0] DrainLast = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        bubble;

  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = branch_target & ~32'd3;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          pc_d   = target_aligned;
          bubble = 1'b1;
        end else if ((instruction == HALT_WORD) && !stall) begin
          // Halt word never enters IF/ID; PC parks on it while the pipe drains.
          bubble  = 1'b1;
          state_d = StDrain;
          cnt_d   = 4'd0;
        end else if (flush) begin
          pc_d   = pc_plus4;
          bubble = 1'b1;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          instr_d = instruction;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      StDrain: begin
        bubble = 1'b1;
        if (branch_taken) begin
          // Halt was on a wrong path: resume fetching at the target.
          pc_d    = target_aligned;
          state_d = StRun;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == DrainLast) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        // Frozen until reset.
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (bubble) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign address     = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_control.sv
// Directed testbench for fetch_control with a scoreboard of expected post-edge outputs.
module tb_fetch_control;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, br;
  logic [31:0] target;
  logic [31:0] address, instruction, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted;

  logic [31:0] addr2, instr2, pc4_2;
  logic        valid2, halted2;

  logic [31:0] mem [0:63];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  fetch_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (br),
    .branch_target (target),
    .address       (address),
    .instruction   (instruction),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  // Second instance exercises the PC wrap from the top of the address space.
  fetch_control #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (1'b0),
    .flush         (1'b0),
    .branch_taken  (1'b0),
    .branch_target (32'd0),
    .address       (addr2),
    .instruction   (32'h0000_0001),
    .if_id_instr   (instr2),
    .if_id_pc4     (pc4_2),
    .if_id_valid   (valid2),
    .halted        (halted2)
  );

  assign instruction = mem[address[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] a, input logic [31:0] i,
                      input logic [31:0] p, input logic v, input logic h);
    exp_t e;
    e.tag = tag; e.addr = a; e.instr = i; e.pc4 = p; e.valid = v; e.halted = h;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".address"}, address, e.addr);
      chk({e.tag, ".instr"}, if_id_instr, e.instr);
      chk({e.tag, ".pc4"}, if_id_pc4, e.pc4);
      chk({e.tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
      chk({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.halted});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0]  = 32'ha102_0000;
    mem[1]  = 32'h810a_fffc;
    mem[2]  = 32'h0083_1820;
    mem[12] = 32'hffff_ffff;

    stall = 1'b0; flush = 1'b0; br = 1'b0; target = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    push("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    compare_head();
    chk("wrap_reset_addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    push("seq0", 32'd4, 32'ha102_0000, 32'd4, 1'b1, 1'b0); cyc();
    chk("wrap_addr", addr2, 32'd0);
    chk("wrap_pc4", pc4_2, 32'd0);
    chk("wrap_instr", instr2, 32'h0000_0001);
    chk("wrap_valid", {31'd0, valid2}, 32'd1);
    push("seq1", 32'd8, 32'h810a_fffc, 32'd8, 1'b1, 1'b0); cyc();

    // Stall holds everything
    stall = 1'b1;
    repeat (3) begin
      push("stall", 32'd8, 32'h810a_fffc, 32'd8, 1'b1, 1'b0); cyc();
    end
    stall = 1'b0;
    push("seq2", 32'd12, 32'h0083_1820, 32'd12, 1'b1, 1'b0); cyc();

    // Branch wins over simultaneous stall; low target bits dropped
    br = 1'b1; target = 32'h0000_0007; stall = 1'b1;
    push("br_bubble", 32'd4, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    br = 1'b0; stall = 1'b0;
    push("br_target", 32'd8, 32'h810a_fffc, 32'd8, 1'b1, 1'b0); cyc();

    flush = 1'b1;
    push("flush", 32'd12, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    flush = 1'b0;

    // Halt drain
    br = 1'b1; target = 32'h20;
    push("br20", 32'h20, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    br = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push("nops", 32'h20 + 32'(4 * k), 32'd0, 32'h20 + 32'(4 * k), 1'b1, 1'b0); cyc();
    end
    stall = 1'b1;
    push("halt_stalled", 32'h30, 32'd0, 32'h30, 1'b1, 1'b0); cyc();
    stall = 1'b0;
    push("drain_entry", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    stall = 1'b1; flush = 1'b1;
    repeat (3) begin
      push("drain", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    end
    stall = 1'b0; flush = 1'b0;
    push("halted_rise", 32'h30, 32'd0, 32'd0, 1'b0, 1'b1); cyc();
    for (int k = 0; k < 4; k++) begin
      stall = k[0]; flush = k[1]; br = ~k[0]; target = 32'h40 + 32'(k);
      push("halted_frozen", 32'h30, 32'd0, 32'd0, 1'b0, 1'b1); cyc();
    end

    // Asynchronous reset mid-cycle clears outputs immediately
    #3 rst_n = 1'b0;
    #2;
    push("async_reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); compare_head();
    br = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push("resume", 32'd4, 32'ha102_0000, 32'd4, 1'b1, 1'b0); cyc();

    // Wrong-path halt: branch two cycles into DRAIN
    br = 1'b1; target = 32'h30;
    push("wp_br30", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    br = 1'b0;
    push("wp_entry", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    repeat (2) begin
      push("wp_drain", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    end
    br = 1'b1; target = 32'd0;
    push("wp_redirect", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    br = 1'b0;
    push("wp_fetch0", 32'd4, 32'ha102_0000, 32'd4, 1'b1, 1'b0); cyc();
    push("wp_fetch1", 32'd8, 32'h810a_fffc, 32'd8, 1'b1, 1'b0); cyc();

    // Reset mid-DRAIN
    br = 1'b1; target = 32'h30;
    push("rd_br30", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    br = 1'b0;
    push("rd_entry", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    push("rd_drain", 32'h30, 32'd0, 32'd0, 1'b0, 1'b0); cyc();
    #3 rst_n = 1'b0;
    #2;
    push("rd_reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0); compare_head();
    @(negedge clk);
    rst_n = 1'b1;
    push("rd_resume", 32'd4, 32'ha102_0000, 32'd4, 1'b1, 1'b0); cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
